// File: rtl/hc165_scan_ctrl_pkg.sv
// Shared definitions for the 74HC165 chain scanner: FSM state encoding and
// word-width derivation from the number of cascaded chips.
package hc165_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_SCLK_HI = 3'd3,
    ST_SCLK_LO = 3'd4,
    ST_DONE    = 3'd5
  } scan_state_e;

  localparam int unsigned BITS_PER_CHIP = 8;

  function automatic int unsigned chain_width(input int unsigned num_chips);
    return BITS_PER_CHIP * num_chips;
  endfunction

endpackage

// File: rtl/hc165_scan_ctrl_tick_gen.sv
// Clock-enable divider: tick pulses on the last count of every CLK_DIV
// cycles; clr holds the counter at zero so the next period starts cleanly.
module hc165_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST)) cnt_d = '0;
    else                        cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/hc165_scan_ctrl.sv
// Scans a daisy-chain of 74HC165 shift registers and presents the captured
// word with a one-cycle valid strobe; the first bit shifted out lands in the MSB.
module hc165_scan_ctrl
  import hc165_scan_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CHIPS  = 1,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CONTINUOUS = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 ser_in,
  output logic                                 sh_ld_n,
  output logic                                 sclk,
  output logic [chain_width(NUM_CHIPS)-1:0]    data_out,
  output logic                                 data_valid,
  output logic                                 busy
);

  localparam int unsigned W     = chain_width(NUM_CHIPS);
  localparam int unsigned CNT_W = $clog2(W + 1);

  scan_state_e      state_q, state_d;
  logic [W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [W-1:0]     data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             sh_ld_n_q, sh_ld_n_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             tick;
  logic             div_clr;

  // Holding the divider clear in IDLE and DONE guarantees LOAD starts at count 0.
  assign div_clr = (state_q == ST_IDLE) || (state_q == ST_DONE);

  hc165_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    case (state_q)
      ST_IDLE:    if (start || (CONTINUOUS != 0)) state_d = ST_LOAD;
      ST_LOAD:    if (tick) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (tick) begin
          sr_d      = {sr_q[W-2:0], ser_in};
          bit_cnt_d = CNT_W'(1);
          state_d   = ST_SCLK_HI;
        end
      end
      ST_SCLK_HI: if (tick) state_d = (bit_cnt_q == CNT_W'(W)) ? ST_DONE : ST_SCLK_LO;
      ST_SCLK_LO: begin
        // Sample at the end of the low phase, well after the '165 moved Q.
        if (tick) begin
          sr_d      = {sr_q[W-2:0], ser_in};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          state_d   = ST_SCLK_HI;
        end
      end
      ST_DONE: begin
        data_out_d   = sr_q;
        data_valid_d = 1'b1;
        state_d      = (CONTINUOUS != 0) ? ST_LOAD : ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
    // Pin outputs are registered from the next state so they align with it.
    sh_ld_n_d = (state_d != ST_LOAD);
    sclk_d    = (state_d == ST_SCLK_HI);
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      sh_ld_n_q    <= 1'b1;
      sclk_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      sh_ld_n_q    <= sh_ld_n_d;
      sclk_q       <= sclk_d;
      busy_q       <= busy_d;
    end
  end

  assign sh_ld_n    = sh_ld_n_q;
  assign sclk       = sclk_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;

endmodule
